// File: rtl/adder_ctrl_pkg.sv
// Purpose: shared state encodings and nibble width for the serial add/subtract controller.
package adder_ctrl_pkg;

    localparam int unsigned NIB_W = 4;

    // Encoding 2'd3 is unused; the controller treats it as a return to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_4b.sv
// Purpose: 4-bit carry-lookahead adder slice, purely combinational.
// Ports:
//   i_a, i_b    : 4-bit operands
//   i_c         : carry in
//   o_sum_c     : 4-bit sum
//   o_cout_c    : carry out of bit 3
module cla_4b (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_sum_c,
    output logic       o_cout_c
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Lookahead carries, each expanded from the slice carry-in.
    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_sum_c  = w_p ^ w_c[3:0];
    assign o_cout_c = w_c[4];

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Purpose: sequences one WIDTH-bit add/subtract through a single shared cla_4b,
//          one nibble per cycle LSB first, and presents the result on valid/ready.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation request handshake (in_ready is combinational)
//   op_sub              : 0 = a+b+c_in, 1 = a-b (c_in ignored)
//   a, b, c_in          : operands and add carry-in
//   out_valid/out_ready : result handshake
//   sum, c_out, ovf     : registered result, carry out (sub: 1 = no borrow), signed overflow
module cla_serial_add_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned NNIB  = WIDTH / NIB_W;
    localparam int unsigned CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;

    if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_bad_width
        $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           w_accept;
    logic                           w_in_ready;
    logic                           w_last;
    logic [CNT_W-1:0]               r_nib_cnt;
    logic [NNIB-1:0][NIB_W-1:0]     r_a;
    logic [NNIB-1:0][NIB_W-1:0]     r_b_eff;
    logic [NNIB-1:0][NIB_W-1:0]     r_sum;
    logic                           r_carry;
    logic                           r_c_out;
    logic                           r_ovf;
    logic                           r_out_valid;
    logic [NIB_W-1:0]               w_a_nib;
    logic [NIB_W-1:0]               w_b_nib;
    logic [NIB_W-1:0]               w_cla_sum;
    logic                           w_cla_cout;

    assign w_last  = (r_nib_cnt == CNT_W'(NNIB - 1));
    assign w_a_nib = r_a[r_nib_cnt];
    assign w_b_nib = r_b_eff[r_nib_cnt];

    cla_4b u_cla (
        .i_a      (w_a_nib),
        .i_b      (w_b_nib),
        .i_c      (r_carry),
        .o_sum_c  (w_cla_sum),
        .o_cout_c (w_cla_cout)
    );

    // Next-state and handshake decode; DONE can retire and accept in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_in_ready = 1'b1;
                    if (in_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and result-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Operand capture and per-nibble accumulation through the shared slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nib_cnt <= '0;
            r_a       <= '0;
            r_b_eff   <= '0;
            r_carry   <= 1'b0;
            r_sum     <= '0;
            r_c_out   <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_nib_cnt <= '0;
            r_a       <= a;
            r_b_eff   <= op_sub ? ~b : b;
            r_carry   <= op_sub | c_in;
        end else if (r_state == ST_RUN) begin
            r_sum[r_nib_cnt] <= w_cla_sum;
            r_carry          <= w_cla_cout;
            if (w_last) begin
                r_c_out <= w_cla_cout;
                // Like-signed operands producing an opposite-signed result.
                r_ovf   <= (r_a[NNIB-1][NIB_W-1] == r_b_eff[NNIB-1][NIB_W-1])
                         & (w_cla_sum[NIB_W-1] != r_a[NNIB-1][NIB_W-1]);
            end else begin
                r_nib_cnt <= r_nib_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;

endmodule
